sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter.sv | 141 ++++++++++++++
 tb/tb_sdram_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// SDRAM access arbiter: NCH requesters share one SDRAM port, one access per SLOT+2 clocks.
// Define SDRAM_ARBITER_ROUND_ROBIN_EN for rotating priority; default build is fixed priority.
module sdram_arbiter #(
   parameter int unsigned NCH  = 3,
   parameter int unsigned AW   = 25,
   parameter int unsigned DW   = 8,
   parameter int unsigned SLOT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NCH-1:0]    req,
   input  logic [NCH-1:0]    wr,
   input  logic [NCH*AW-1:0] addr,
   input  logic [NCH*DW-1:0] din,
   output logic [NCH-1:0]    gnt,
   output logic [NCH-1:0]    ack,
   output logic [DW-1:0]     rdata,
   output logic              busy,
   output logic [AW-1:0]     sd_addr,
   output logic [DW-1:0]     sd_din,
   output logic              sd_we,
   output logic              sd_oe,
   input  logic [DW-1:0]     sd_dout
);

   localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned CW = (SLOT > 1) ? $clog2(SLOT) : 1;

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]   win_q, win_d;
   logic            wr_q, wr_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   din_q, din_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic [IW-1:0]   pick;

`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
   logic [IW-1:0]   ptr_q, ptr_d;
   int unsigned     idx;

   // Descending scan so the final assignment is the first requester after ptr_q.
   always_comb begin
      pick = '0;
      idx  = 0;
      for (int k = int'(NCH) - 1; k >= 0; k--) begin
         idx = (32'(ptr_q) + 32'd1 + unsigned'(k)) % NCH;
         if (req[idx[IW-1:0]]) pick = idx[IW-1:0];
      end
   end
`else
   always_comb begin
      pick = '0;
      for (int i = int'(NCH) - 1; i >= 0; i--) begin
         if (req[i]) pick = IW'(i);
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      win_d   = win_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      din_d   = din_q;
      rdata_d = rdata_q;
`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
      ptr_d   = ptr_q;
`endif
      case (state_q)
         StIdle: begin
            if (|req) begin
               win_d   = pick;
               wr_d    = wr[pick];
               addr_d  = addr[32'(pick)*AW +: AW];
               din_d   = din[32'(pick)*DW +: DW];
               cnt_d   = CW'(SLOT - 1);
               state_d = StAccess;
`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
               ptr_d   = pick;
`endif
            end
         end
         StAccess: begin
            if (cnt_q == '0) begin
               state_d = StDone;
               // Read data is captured on the last access clock.
               if (!wr_q) rdata_d = sd_dout;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         win_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
         rdata_q <= '0;
`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
         ptr_q   <= IW'(NCH - 1);
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         win_q   <= win_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         rdata_q <= rdata_d;
`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   always_comb begin
      gnt = '0;
      ack = '0;
      if (state_q == StAccess) gnt[win_q] = 1'b1;
      if (state_q == StDone)   ack[win_q] = 1'b1;
   end

   assign busy    = (state_q != StIdle);
   assign sd_we   = (state_q == StAccess) &&  wr_q;
   assign sd_oe   = (state_q == StAccess) && !wr_q;
   assign sd_addr = addr_q;
   assign sd_din  = din_q;
   assign rdata   = rdata_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter (NCH=3, SLOT=4); honours SDRAM_ARBITER_ROUND_ROBIN_EN.
module tb_sdram_arbiter;

   localparam int NCH  = 3;
   localparam int AW   = 25;
   localparam int DW   = 8;
   localparam int SLOT = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [NCH-1:0]    req, wr, gnt, ack;
   logic [NCH*AW-1:0] addr;
   logic [NCH*DW-1:0] din;
   logic [DW-1:0]     rdata, sd_din, sd_dout;
   logic [AW-1:0]     sd_addr;
   logic              busy, sd_we, sd_oe;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int            ch;
      logic [DW-1:0] rd;
   } exp_t;
   exp_t          sb[$];
   logic [DW-1:0] model_rdata = '0;

   sdram_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .SLOT(SLOT)) dut (
      .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .din(din),
      .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy), .sd_addr(sd_addr),
      .sd_din(sd_din), .sd_we(sd_we), .sd_oe(sd_oe), .sd_dout(sd_dout)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Single access; req/addr/din/wr are disturbed after the grant edge.
   task automatic access(input int ch, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] sdo);
      exp_t e;
      if (!w) model_rdata = sdo;
      e.ch = ch;
      e.rd = model_rdata;
      sb.push_back(e);
      req[ch] = 1'b1;
      wr[ch]  = w;
      addr[ch*AW +: AW] = a;
      din[ch*DW +: DW]  = d;
      sd_dout = sdo;
      step();
      req[ch] = 1'b0;
      wr[ch]  = ~w;
      addr[ch*AW +: AW] = ~a;
      din[ch*DW +: DW]  = ~d;
      for (int c = 0; c < SLOT; c++) begin
         chk("acc_gnt", 32'(gnt), 32'(1 << ch));
         chk("acc_we", 32'(sd_we), 32'(w));
         chk("acc_oe", 32'(sd_oe), 32'(!w));
         chk("acc_addr", 32'(sd_addr), 32'(a));
         chk("acc_din", 32'(sd_din), 32'(d));
         chk("acc_busy", 32'(busy), 32'd1);
         chk("acc_noack", 32'(ack), 32'd0);
         step();
      end
      e = sb.pop_front();
      chk("done_ack", 32'(ack), 32'(1 << e.ch));
      chk("done_rdata", 32'(rdata), 32'(e.rd));
      chk("done_gnt", 32'(gnt), 32'd0);
      chk("done_strobes", 32'({sd_we, sd_oe}), 32'd0);
      chk("done_busy", 32'(busy), 32'd1);
      step();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_ack", 32'(ack), 32'd0);
      chk("idle_addr_hold", 32'(sd_addr), 32'(a));
   endtask

   initial begin
      int         exp_win [4];
      int         cyc;
      logic [NCH-1:0] ack_seen;

      reset = 1'b1; req = '0; wr = '0; addr = '0; din = '0; sd_dout = '0;
      step();
      step();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_strobes", 32'({sd_we, sd_oe}), 32'd0);
      chk("rst_addr", 32'(sd_addr), 32'd0);
      chk("rst_din", 32'(sd_din), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);

      // First arbitration on the first clock after reset release.
      reset = 1'b0;
      access(1, 1'b1, 25'h000123, 8'hA5, 8'hEE);
      access(2, 1'b0, 25'h0001ABC, 8'h11, 8'h3C);
      access(0, 1'b1, 25'h1FFFFFF, 8'hFF, 8'h77);
      step();
      step();
      chk("hold_rdata", 32'(rdata), 32'h3C);
      chk("hold_addr", 32'(sd_addr), 32'h1FFFFFF);
      chk("hold_din", 32'(sd_din), 32'hFF);
      chk("hold_strobes", 32'({sd_we, sd_oe}), 32'd0);

      // Reset during the second access clock aborts without ack.
      req[1] = 1'b1; wr[1] = 1'b1; addr[1*AW +: AW] = 25'h55;
      step();
      step();
      chk("abort_pre_gnt", 32'(gnt), 32'b010);
      reset = 1'b1;
      req = '0;
      step();
      chk("abort_gnt", 32'(gnt), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_strobes", 32'({sd_we, sd_oe}), 32'd0);
      chk("abort_addr", 32'(sd_addr), 32'd0);
      chk("abort_rdata", 32'(rdata), 32'd0);
      reset = 1'b0;
      model_rdata = '0;
      ack_seen = '0;
      for (int c = 0; c < 12; c++) begin
         ack_seen |= ack;
         step();
      end
      chk("abort_noack", 32'(ack_seen), 32'd0);

      // Contention between channels 0 and 2 held continuously.
`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
      exp_win = '{0, 2, 0, 2};
`else
      exp_win = '{0, 0, 0, 0};
`endif
      reset = 1'b1;
      step();
      reset = 1'b0;
      wr = '1;
      req = 3'b101;
      for (int n = 0; n < 4; n++) begin
         cyc = 0;
         do begin
            step();
            cyc++;
         end while (ack == '0 && cyc < 20);
         chk("cont_timeout", 32'(cyc < 20), 32'd1);
         chk("cont_winner", 32'(ack), 32'(1 << exp_win[n]));
         chk("cont_spacing", 32'(cyc), (n == 0) ? 32'(SLOT + 1) : 32'(SLOT + 2));
      end
      req = '0;
      step();
      chk("cont_idle", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
